daq_fifo_sequencer: RTL and testbench

//  Parametrised event-builder readout sequencer for the DMB control path. It pops one

---
 rtl/daq_seq_pkg.sv | 26 ++
 rtl/daq_chan_sel.sv | 28 ++
 rtl/daq_fifo_sequencer.sv | 147 ++++++++++++++
 tb/tb_daq_fifo_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/daq_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : daq_seq_pkg
// Brief  : Shared state codes, frame tags and limits for the readout sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package daq_seq_pkg;

   localparam int MAX_NCH = 12;

   localparam logic [3:0] TAG_H1 = 4'h9;
   localparam logic [3:0] TAG_H2 = 4'hA;
   localparam logic [3:0] TAG_T1 = 4'hE;
   localparam logic [3:0] TAG_T2 = 4'hF;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR1 = 3'd1;
   localparam logic [2:0] ST_HDR2 = 3'd2;
   localparam logic [2:0] ST_SEL  = 3'd3;
   localparam logic [2:0] ST_READ = 3'd4;
   localparam logic [2:0] ST_TRL1 = 3'd5;
   localparam logic [2:0] ST_TRL2 = 3'd6;
   localparam logic [2:0] ST_POP  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/daq_chan_sel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : daq_chan_sel
// Brief  : Lowest-set-bit encoder over the pending-channel mask.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module daq_chan_sel
   import daq_seq_pkg::*;
#(
   parameter int NCH = 7
) (
   input  logic [NCH-1:0] i_pend,
   output logic [NCH-1:0] o_onehot,
   output logic [3:0]     o_idx,
   output logic           o_none_left
);

   always_comb begin
      o_onehot    = i_pend & (~i_pend + 1'b1);
      o_none_left = ~|i_pend;
      o_idx       = 4'd0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (i_pend[i]) o_idx = 4'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/daq_fifo_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : daq_fifo_sequencer
// Brief  : Per-L1A event builder: frames and reads active channel FIFOs in order.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module daq_fifo_sequencer
   import daq_seq_pkg::*;
#(
   parameter int         NCH  = 7,
   parameter logic [8:0] STMO = 9'd40
) (
   input  logic            CLKCMS,
   input  logic            RST,
   input  logic            L1ARST,
   input  logic            EVT_EMPTY_B,
   input  logic [NCH-1:0]  DAVMASK,
   input  logic [NCH-1:0]  KILL,
   output logic            EVT_POP,
   input  logic [NCH-1:0]  FFOR_B,
   input  logic [16:0]     DATAIN,
   output logic [NCH-1:0]  OE_B,
   output logic [NCH-1:0]  REN_B,
   input  logic            DOUT_RDY,
   output logic [15:0]     DOUT,
   output logic            DOUT_VLD
);

   logic [2:0]         r_state;
   logic [NCH-1:0]     r_pend;
   logic [NCH-1:0]     r_dav;
   logic [MAX_NCH-1:0] r_tmo;
   logic [11:0]        r_l1acnt;
   logic [11:0]        r_wcnt;
   logic [8:0]         r_tcnt;
   logic [15:0]        r_dout;
   logic               r_vld;

   logic [NCH-1:0]     w_onehot;
   logic [3:0]         w_idx;
   logic               w_none;
   logic               w_fifo_rdy;
   logic               w_ren;
   logic [MAX_NCH-1:0] w_dav_ext;

   daq_chan_sel #(.NCH(NCH)) u_sel (
      .i_pend      (r_pend),
      .o_onehot    (w_onehot),
      .o_idx       (w_idx),
      .o_none_left (w_none)
   );

   // The current channel stays the lowest pending bit until its block ends.
   assign w_fifo_rdy = |(w_onehot & ~FFOR_B);
   assign w_ren      = (r_state == ST_READ) && DOUT_RDY && w_fifo_rdy;

   assign OE_B     = (r_state == ST_SEL || r_state == ST_READ) ? ~w_onehot : '1;
   assign REN_B    = w_ren ? ~w_onehot : '1;
   assign EVT_POP  = (r_state == ST_POP);
   assign DOUT     = r_dout;
   assign DOUT_VLD = r_vld;

   always_comb begin
      w_dav_ext          = '0;
      w_dav_ext[NCH-1:0] = r_dav;
   end

   always_ff @(posedge CLKCMS or posedge RST) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_pend   <= '0;
         r_dav    <= '0;
         r_tmo    <= '0;
         r_l1acnt <= '0;
         r_wcnt   <= '0;
         r_tcnt   <= '0;
         r_dout   <= '0;
         r_vld    <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         // A counter clear coinciding with the pop takes priority.
         if (L1ARST)                 r_l1acnt <= '0;
         else if (r_state == ST_POP) r_l1acnt <= r_l1acnt + 12'd1;

         case (r_state)
            ST_IDLE: if (EVT_EMPTY_B) begin
               r_pend  <= DAVMASK & ~KILL;
               r_dav   <= DAVMASK;
               r_state <= ST_HDR1;
            end
            ST_HDR1: if (DOUT_RDY) begin
               r_dout  <= {TAG_H1, r_l1acnt};
               r_vld   <= 1'b1;
               r_wcnt  <= r_wcnt + 12'd1;
               r_state <= ST_HDR2;
            end
            ST_HDR2: if (DOUT_RDY) begin
               r_dout  <= {TAG_H2, w_dav_ext};
               r_vld   <= 1'b1;
               r_wcnt  <= r_wcnt + 12'd1;
               r_state <= ST_SEL;
            end
            ST_SEL: begin
               r_tcnt  <= '0;
               r_state <= w_none ? ST_TRL1 : ST_READ;
            end
            ST_READ: if (DOUT_RDY) begin
               if (w_fifo_rdy) begin
                  r_dout <= DATAIN[15:0];
                  r_vld  <= 1'b1;
                  r_wcnt <= r_wcnt + 12'd1;
                  r_tcnt <= '0;
                  if (DATAIN[16]) begin
                     r_pend  <= r_pend & ~w_onehot;
                     r_state <= ST_SEL;
                  end
               end else if (r_tcnt == STMO - 9'd1) begin
                  r_tmo[w_idx] <= 1'b1;
                  r_pend       <= r_pend & ~w_onehot;
                  r_state      <= ST_SEL;
               end else begin
                  r_tcnt <= r_tcnt + 9'd1;
               end
            end
            ST_TRL1: if (DOUT_RDY) begin
               r_dout  <= {TAG_T1, r_tmo};
               r_vld   <= 1'b1;
               r_wcnt  <= r_wcnt + 12'd1;
               r_state <= ST_TRL2;
            end
            ST_TRL2: if (DOUT_RDY) begin
               r_dout  <= {TAG_T2, r_wcnt};
               r_vld   <= 1'b1;
               r_state <= ST_POP;
            end
            ST_POP: begin
               r_wcnt  <= '0;
               r_tmo   <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_daq_fifo_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_daq_fifo_sequencer
// Brief  : Directed self-checking bench for daq_fifo_sequencer with FWFT FIFO model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_daq_fifo_sequencer;

   localparam int NCH = 7;

   logic            CLKCMS = 1'b0;
   logic            RST;
   logic            L1ARST;
   logic            EVT_EMPTY_B;
   logic [NCH-1:0]  DAVMASK;
   logic [NCH-1:0]  KILL;
   logic            EVT_POP;
   logic [NCH-1:0]  FFOR_B;
   logic [16:0]     DATAIN;
   logic [NCH-1:0]  OE_B;
   logic [NCH-1:0]  REN_B;
   logic            DOUT_RDY;
   logic [15:0]     DOUT;
   logic            DOUT_VLD;

   daq_fifo_sequencer #(.NCH(NCH), .STMO(9'd40)) dut (
      .CLKCMS      (CLKCMS),
      .RST         (RST),
      .L1ARST      (L1ARST),
      .EVT_EMPTY_B (EVT_EMPTY_B),
      .DAVMASK     (DAVMASK),
      .KILL        (KILL),
      .EVT_POP     (EVT_POP),
      .FFOR_B      (FFOR_B),
      .DATAIN      (DATAIN),
      .OE_B        (OE_B),
      .REN_B       (REN_B),
      .DOUT_RDY    (DOUT_RDY),
      .DOUT        (DOUT),
      .DOUT_VLD    (DOUT_VLD)
   );

   always #10 CLKCMS = ~CLKCMS;

   // Channel FIFO model: first-word-fall-through, data driven only while OE_B is low.
   logic [16:0] mem    [NCH][64];
   logic [5:0]  wr_ptr [NCH];
   logic [5:0]  rd_ptr [NCH] = '{default: 6'd0};

   always @(posedge CLKCMS) begin
      for (int c = 0; c < NCH; c++) begin
         if (!REN_B[c]) rd_ptr[c] <= rd_ptr[c] + 6'd1;
      end
   end

   always_comb begin
      DATAIN = '0;
      FFOR_B = '1;
      for (int c = 0; c < NCH; c++) begin
         FFOR_B[c] = (wr_ptr[c] == rd_ptr[c]);
         if (!OE_B[c]) DATAIN = mem[c][rd_ptr[c]];
      end
   end

   int             total = 0;
   int             bad   = 0;
   logic [15:0]    got[$];
   logic [15:0]    exp_w[$];
   int             pops;
   logic           ren_seen;
   logic [NCH-1:0] oe_seen;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, req);
      end
   endtask

   task automatic push(input int ch, input logic [16:0] w);
      mem[ch][wr_ptr[ch]] = w;
      wr_ptr[ch] = wr_ptr[ch] + 6'd1;
   endtask

   task automatic run_event(input logic [NCH-1:0] mask, input logic [NCH-1:0] kill,
                            input bit tog, input bit late_kill, input bit l1a_pop);
      got.delete();
      pops     = 0;
      ren_seen = 1'b0;
      oe_seen  = '0;
      DAVMASK     = mask;
      KILL        = kill;
      EVT_EMPTY_B = 1'b1;
      for (int cyc = 0; cyc < 600 && pops == 0; cyc++) begin
         @(negedge CLKCMS);
         if (DOUT_VLD) got.push_back(DOUT);
         if (REN_B != '1) ren_seen = 1'b1;
         oe_seen = oe_seen | ~OE_B;
         if (late_kill && got.size() > 0) KILL = '0;
         DOUT_RDY = tog ? ~DOUT_RDY : 1'b1;
         if (EVT_POP) begin
            pops++;
            EVT_EMPTY_B = 1'b0;
            if (l1a_pop) L1ARST = 1'b1;
         end
      end
      check("evt_pop_seen", pops, 1);
      @(negedge CLKCMS);
      L1ARST   = 1'b0;
      DOUT_RDY = 1'b1;
      check("evt_pop_width", {31'd0, EVT_POP}, 0);
   endtask

   task automatic cmp_words(input string tag);
      check($sformatf("%s_len", tag), got.size(), exp_w.size());
      for (int i = 0; i < exp_w.size(); i++) begin
         check($sformatf("%s_w%0d", tag, i),
               (i < got.size()) ? {16'd0, got[i]} : 32'hDEAD_0000, {16'd0, exp_w[i]});
      end
   endtask

   initial begin
      RST = 1'b1; L1ARST = 1'b0; EVT_EMPTY_B = 1'b0;
      DAVMASK = '0; KILL = '0; DOUT_RDY = 1'b1;
      for (int c = 0; c < NCH; c++) wr_ptr[c] = 6'd0;
      repeat (3) @(negedge CLKCMS);
      check("rst_oe",   {25'd0, OE_B},  32'h7F);
      check("rst_ren",  {25'd0, REN_B}, 32'h7F);
      check("rst_dout", {16'd0, DOUT},  0);
      check("rst_vld",  {31'd0, DOUT_VLD}, 0);
      check("rst_pop",  {31'd0, EVT_POP}, 0);
      RST = 1'b0;
      @(negedge CLKCMS);

      // 1: two channels, blocks of 3 and 2 words
      push(0, 17'h01110); push(0, 17'h01111); push(0, 17'h11112);
      push(2, 17'h03330); push(2, 17'h13331);
      run_event(7'b0000101, 7'b0, 0, 0, 0);
      exp_w = '{16'h9000, 16'hA005, 16'h1110, 16'h1111, 16'h1112,
                16'h3330, 16'h3331, 16'hE000, 16'hF008};
      cmp_words("t1");

      // 2: active channel never becomes ready -> timeout
      run_event(7'b0000010, 7'b0, 0, 0, 0);
      exp_w = '{16'h9001, 16'hA002, 16'hE002, 16'hF003};
      cmp_words("t2");
      check("t2_ren_never", {31'd0, ren_seen}, 0);

      // 3: killed channel untouched even though KILL drops mid-event
      push(0, 17'h01AA0); push(0, 17'h11AA1);
      push(1, 17'h12220);
      run_event(7'b0000011, 7'b0000001, 0, 1, 0);
      exp_w = '{16'h9002, 16'hA003, 16'h2220, 16'hE000, 16'hF004};
      cmp_words("t3");
      check("t3_oe0_high", {31'd0, oe_seen[0]}, 0);
      check("t3_ch0_ptr",  {26'd0, rd_ptr[0]}, 32'd3);

      // 4: backpressure toggling every cycle
      push(2, 17'h03AA0); push(2, 17'h03AA1); push(2, 17'h13AA2);
      run_event(7'b0000101, 7'b0, 1, 0, 0);
      exp_w = '{16'h9003, 16'hA005, 16'h1AA0, 16'h1AA1, 16'h3AA0,
                16'h3AA1, 16'h3AA2, 16'hE000, 16'hF008};
      cmp_words("t4");

      // 5: asynchronous reset while reading ch2
      push(2, 17'h04440); push(2, 17'h04441); push(2, 17'h04442); push(2, 17'h14443);
      got.delete(); pops = 0;
      DAVMASK = 7'b0000100; KILL = '0; EVT_EMPTY_B = 1'b1;
      for (int cyc = 0; cyc < 100 && got.size() < 3; cyc++) begin
         @(negedge CLKCMS);
         if (DOUT_VLD) got.push_back(DOUT);
         if (EVT_POP) pops++;
      end
      check("t5_in_read", got.size(), 3);
      check("t5_ren_pre", {25'd0, REN_B}, 32'h7B);
      RST = 1'b1;
      #1;
      check("t5_oe",   {25'd0, OE_B},  32'h7F);
      check("t5_ren",  {25'd0, REN_B}, 32'h7F);
      check("t5_vld",  {31'd0, DOUT_VLD}, 0);
      check("t5_dout", {16'd0, DOUT}, 0);
      EVT_EMPTY_B = 1'b0;
      @(negedge CLKCMS);
      if (EVT_POP) pops++;
      RST = 1'b0;
      check("t5_no_pop", pops, 0);
      run_event(7'b0, 7'b0, 0, 0, 0);
      exp_w = '{16'h9000, 16'hA000, 16'hE000, 16'hF003};
      cmp_words("t5_next");

      // 6: L1A counter wrap and clear-at-pop priority
      @(negedge CLKCMS); L1ARST = 1'b1;
      @(negedge CLKCMS); L1ARST = 1'b0;
      for (int n = 0; n < 4098; n++) begin
         run_event(7'b0, 7'b0, 0, 0, n == 4096);
         exp_w = '{16'h9000 | 16'(n % 4096), 16'hA000, 16'hE000, 16'hF003};
         if (n == 4097) exp_w[0] = 16'h9000;
         cmp_words($sformatf("t6_%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
